fp_addsub_scheduler: RTL and testbench

- Time-shares one combinational IEEE-754 single-precision adder/subtractor (Addition_Subtraction) among NUM_REQ neuron-update requesters in the SNN accelerator.
- Round-robin arbitration, valid/ready request handshake, two-stage registered pipeline, one-hot tagged responses.
- Throughput 1 op/cycle; fixed latency.

---
 rtl/fp_addsub_scheduler_pkg.sv | 22 ++
 rtl/Addition_Subtraction.sv | 71 +++++++
 rtl/fp_addsub_scheduler_rr_arbiter.sv | 31 +++
 rtl/fp_addsub_scheduler.sv | 107 ++++++++++
 tb/tb_fp_addsub_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_addsub_scheduler_pkg.sv
// Shared widths, opcodes and FP constants for the add/sub scheduler and its
// clients.
package fp_addsub_scheduler_pkg;

  localparam int FP_WIDTH = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [FP_WIDTH-1:0] FP_ONE     = 32'h3F80_0000;
  localparam logic [FP_WIDTH-1:0] FP_POS_INF = 32'h7F80_0000;

  typedef logic [FP_WIDTH-1:0] fp_t;

  // One issued operation as held in the issue stage.
  typedef struct packed {
    fp_t  a;
    fp_t  b;
    logic sub;
  } fp_op_t;

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational single-precision adder/subtractor shared by the scheduler.
// Truncating alignment; Exception flags any all-ones exponent on an operand.
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);

  logic        swap;
  logic [31:0] bEff;
  logic [31:0] opBig;
  logic [31:0] opSmall;
  logic [7:0]  expBig;
  logic [7:0]  expSmall;
  logic [7:0]  expDiff;
  logic [23:0] manBig;
  logic [23:0] manSmall;
  logic [23:0] manAligned;
  logic [24:0] manSum;
  logic [23:0] manDiff;
  logic [4:0]  lz;
  logic [23:0] manNorm;
  logic [7:0]  expOut;
  logic [22:0] fracOut;
  logic        signOut;

  assign Exception = (&a_operand[30:23]) | (&b_operand[30:23]);

  // Order operands by magnitude so the difference path never goes negative.
  assign bEff       = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
  assign swap       = b_operand[30:0] > a_operand[30:0];
  assign opBig      = swap ? bEff : a_operand;
  assign opSmall    = swap ? a_operand : bEff;
  assign expBig     = opBig[30:23];
  assign expSmall   = opSmall[30:23];
  assign expDiff    = expBig - expSmall;
  assign manBig     = {|expBig, opBig[22:0]};
  assign manSmall   = {|expSmall, opSmall[22:0]};
  assign manAligned = manSmall >> expDiff;
  assign manSum     = {1'b0, manBig} + {1'b0, manAligned};
  assign manDiff    = manBig - manAligned;

  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (manDiff[i]) lz = 5'(23 - i);
    end
    manNorm = manDiff << lz;
    expOut  = '0;
    fracOut = '0;
    signOut = 1'b0;
    if (opBig[31] == opSmall[31]) begin
      signOut = opBig[31];
      if (manSum[24]) begin
        expOut  = expBig + 8'd1;
        fracOut = manSum[23:1];
      end else begin
        expOut  = expBig;
        fracOut = manSum[22:0];
      end
    end else if (manNorm[23] && ({3'b000, lz} < expBig)) begin
      signOut = opBig[31];
      expOut  = expBig - {3'b000, lz};
      fracOut = manNorm[22:0];
    end
    result = {signOut, expOut, fracOut};
  end

endmodule

// File: rtl/fp_addsub_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins,
// searching upward with wrap.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grantId_o
);

  localparam int IW = $clog2(N);

  always_comb begin
    int   idx;
    logic found;
    grant_o   = '0;
    grantId_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grantId_o    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_addsub_scheduler.sv
// Round-robin scheduler time-sharing one FP adder/subtractor among NUM_REQ
// requesters through a two-register pipeline with one-hot tagged responses.
module fp_addsub_scheduler
  import fp_addsub_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [FP_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [FP_WIDTH*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]          req_sub,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [FP_WIDTH-1:0]         rsp_result,
  output logic                        rsp_exception,
  output logic                        busy,
  output logic [31:0]                 op_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grantId;
  logic               accept;

  logic [ID_W-1:0]    rrPtr_q, rrPtr_d;
  logic               s1Valid_q, s1Valid_d;
  fp_op_t             s1Op_q, s1Op_d;
  logic [ID_W-1:0]    s1Id_q, s1Id_d;
  logic               s2Valid_q;
  logic [ID_W-1:0]    s2Id_q;
  fp_t                rspResult_q;
  logic               rspException_q;
  logic [31:0]        opCount_q;

  fp_t                addResult;
  logic               addException;

  rr_arbiter #(.N(NUM_REQ)) uArbiter (
    .req_i     (req_valid),
    .ptr_i     (rrPtr_q),
    .grant_o   (grant),
    .grantId_o (grantId)
  );

  Addition_Subtraction uAdder (
    .a_operand  (s1Op_q.a),
    .b_operand  (s1Op_q.b),
    .AddBar_Sub (s1Op_q.sub),
    .Exception  (addException),
    .result     (addResult)
  );

  // Grants are suppressed during reset so nothing looks accepted while the
  // pipeline is being cleared.
  assign req_ready = RESET ? '0 : grant;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    rrPtr_d   = rrPtr_q;
    s1Valid_d = accept;
    s1Op_d    = s1Op_q;
    s1Id_d    = s1Id_q;
    if (accept) begin
      rrPtr_d    = (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + ID_W'(1);
      s1Op_d.a   = req_a[int'(grantId)*FP_WIDTH +: FP_WIDTH];
      s1Op_d.b   = req_b[int'(grantId)*FP_WIDTH +: FP_WIDTH];
      s1Op_d.sub = req_sub[grantId];
      s1Id_d     = grantId;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rrPtr_q        <= '0;
      s1Valid_q      <= 1'b0;
      s1Op_q         <= '0;
      s1Id_q         <= '0;
      s2Valid_q      <= 1'b0;
      s2Id_q         <= '0;
      rspResult_q    <= '0;
      rspException_q <= 1'b0;
      opCount_q      <= '0;
    end else begin
      rrPtr_q   <= rrPtr_d;
      s1Valid_q <= s1Valid_d;
      s1Op_q    <= s1Op_d;
      s1Id_q    <= s1Id_d;
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Id_q         <= s1Id_q;
        rspResult_q    <= addResult;
        rspException_q <= addException;
      end
      if (s2Valid_q) opCount_q <= opCount_q + 32'd1;
    end
  end

  assign rsp_valid     = s2Valid_q ? (NUM_REQ'(1) << s2Id_q) : '0;
  assign rsp_result    = rspResult_q;
  assign rsp_exception = rspException_q;
  assign busy          = s1Valid_q | s2Valid_q;
  assign op_count      = opCount_q;

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Scoreboard bench for fp_addsub_scheduler: directed requests push expected
// responses, a negedge monitor pops and compares whenever rsp_valid fires.
module tb_fp_addsub_scheduler;
   import fp_addsub_scheduler_pkg::*;

   localparam int N = 4;

   localparam logic [31:0] FP_HALF  = 32'h3F00_0000;
   localparam logic [31:0] FP_1P5   = 32'h3FC0_0000;
   localparam logic [31:0] FP_TWO   = 32'h4000_0000;
   localparam logic [31:0] FP_THREE = 32'h4040_0000;
   localparam logic [31:0] FP_FOUR  = 32'h4080_0000;
   localparam logic [31:0] FP_FIVE  = 32'h40A0_0000;
   localparam logic [31:0] FP_TEN   = 32'h4120_0000;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] res;
      logic        exc;
      logic        chk;
   } exp_t;

   logic            CLK = 1'b0;
   logic            RESET = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [32*N-1:0] req_a = '0;
   logic [32*N-1:0] req_b = '0;
   logic [N-1:0]    req_sub = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [31:0]     rsp_result;
   logic            rsp_exception;
   logic            busy;
   logic [31:0]     op_count;

   int errors = 0;
   int checks = 0;

   exp_t        sbQ[$];
   exp_t        monE;
   logic [31:0] expRes [N];
   logic        expExc [N];
   logic        expChk [N];
   logic [N-1:0] pending = '0;

   fp_addsub_scheduler #(.NUM_REQ(N)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .req_valid     (req_valid),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_sub       (req_sub),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_result    (rsp_result),
      .rsp_exception (rsp_exception),
      .busy          (busy),
      .op_count      (op_count)
   );

   // Free-running clock, 10 time-unit period.
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic setOp(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] res, input logic exc, input logic chk);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_sub[i]        = sub;
      expRes[i]         = res;
      expExc[i]         = exc;
      expChk[i]         = chk;
   endtask

   task automatic pushExp(input logic [N-1:0] grant);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            e.id  = 2'(i);
            e.res = expRes[i];
            e.exc = expExc[i];
            e.chk = expChk[i];
            sbQ.push_back(e);
         end
      end
   endtask

   // Drive a request pattern at the negedge, check the grant, and queue the
   // response that the coming posedge's accept should produce.
   task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] expGrant, input logic push);
      @(negedge CLK);
      req_valid = valid;
      #1;
      checkOutput("grant", 32'(req_ready), 32'(expGrant));
      if (push) pushExp(expGrant);
   endtask

   task automatic drain(input logic [31:0] expCount);
      int n;
      n = 0;
      @(negedge CLK);
      req_valid = '0;
      while (busy !== 1'b0 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      #1;
      checkOutput("drain_busy", 32'(busy), 32'd0);
      checkOutput("op_count", op_count, expCount);
      checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
   endtask

   // Response monitor: every presented response must match the queue head.
   always @(negedge CLK) begin
      if (!RESET && rsp_valid != '0) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid %b, required no response", rsp_valid);
         end else begin
            monE = sbQ.pop_front();
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << monE.id));
            checkOutput("rsp_exception", 32'(rsp_exception), 32'(monE.exc));
            if (monE.chk) checkOutput("rsp_result", rsp_result, monE.res);
         end
      end
   end

   // A requester that was not granted must keep its valid asserted.
   always @(posedge CLK) begin
      if (RESET) begin
         pending = '0;
      end else begin
         if (pending != '0) checkOutput("hold_valid", 32'(pending & ~req_valid), 32'd0);
         pending = req_valid & ~req_ready;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      @(negedge CLK);
      #1;
      checkOutput("reset_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_result", rsp_result, 32'd0);
      checkOutput("reset_exception", 32'(rsp_exception), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_op_count", op_count, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      // Single request: 5.0 + 5.0
      setOp(0, FP_FIVE, FP_FIVE, OP_ADD, FP_TEN, 1'b0, 1'b1);
      applyStimulus(4'b0001, 4'b0001, 1'b1);
      drain(32'd1);
      checkOutput("hold_result", rsp_result, FP_TEN);
      checkOutput("hold_exception", 32'(rsp_exception), 32'd0);

      // Full contention straight after reset
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      checkOutput("reset2_op_count", op_count, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      setOp(0, FP_ONE,   FP_ONE,  OP_ADD, FP_TWO,   1'b0, 1'b1);
      setOp(1, FP_TWO,   FP_ONE,  OP_ADD, FP_THREE, 1'b0, 1'b1);
      setOp(2, FP_ONE,   FP_HALF, OP_ADD, FP_1P5,   1'b0, 1'b1);
      setOp(3, FP_THREE, FP_ONE,  OP_SUB, FP_TWO,   1'b0, 1'b1);
      applyStimulus(4'b1111, 4'b0001, 1'b1);
      applyStimulus(4'b1111, 4'b0010, 1'b1);
      checkOutput("contention_busy", 32'(busy), 32'd1);
      applyStimulus(4'b1111, 4'b0100, 1'b1);
      checkOutput("contention_busy", 32'(busy), 32'd1);
      applyStimulus(4'b1111, 4'b1000, 1'b1);
      checkOutput("contention_busy", 32'(busy), 32'd1);
      applyStimulus(4'b1111, 4'b0001, 1'b1);
      checkOutput("contention_busy", 32'(busy), 32'd1);
      applyStimulus(4'b1110, 4'b0010, 1'b1);
      applyStimulus(4'b1100, 4'b0100, 1'b1);
      applyStimulus(4'b1000, 4'b1000, 1'b1);
      checkOutput("contention_busy", 32'(busy), 32'd1);
      drain(32'd8);

      // Pointer fairness: after req1, req2 beats req0
      setOp(1, FP_TWO, FP_TWO,  OP_ADD, FP_FOUR, 1'b0, 1'b1);
      setOp(2, FP_ONE, FP_HALF, OP_ADD, FP_1P5,  1'b0, 1'b1);
      setOp(0, FP_ONE, FP_ONE,  OP_ADD, FP_TWO,  1'b0, 1'b1);
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      applyStimulus(4'b0101, 4'b0100, 1'b1);
      applyStimulus(4'b0001, 4'b0001, 1'b1);
      drain(32'd11);

      // Subtract on req3: 3.0 - 1.0
      setOp(3, FP_THREE, FP_ONE, OP_SUB, FP_TWO, 1'b0, 1'b1);
      applyStimulus(4'b1000, 4'b1000, 1'b1);
      drain(32'd12);

      // Exception on req2: +Inf + 1.0
      setOp(2, FP_POS_INF, FP_ONE, OP_ADD, 32'd0, 1'b1, 1'b0);
      applyStimulus(4'b0100, 4'b0100, 1'b1);
      drain(32'd13);
      checkOutput("hold_exception_set", 32'(rsp_exception), 32'd1);

      // Reset with an operation in flight; it must never respond
      setOp(1, FP_ONE, FP_ONE, OP_ADD, FP_TWO, 1'b0, 1'b1);
      applyStimulus(4'b0010, 4'b0010, 1'b0);
      @(negedge CLK);
      RESET = 1'b1;
      req_valid = 4'b1001;
      setOp(0, FP_ONE,   FP_ONE, OP_ADD, FP_TWO, 1'b0, 1'b1);
      setOp(3, FP_THREE, FP_ONE, OP_SUB, FP_TWO, 1'b0, 1'b1);
      #1;
      checkOutput("midreset_ready", 32'(req_ready), 32'd0);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_op_count", op_count, 32'd0);
      repeat (2) @(negedge CLK);
      #1;
      checkOutput("midreset_ready_held", 32'(req_ready), 32'd0);
      checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      checkOutput("release_grant", 32'(req_ready), 32'b0001);
      pushExp(4'b0001);
      applyStimulus(4'b1000, 4'b1000, 1'b1);
      drain(32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
